// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall/flush chain, multi-cycle divide hold and
// precise-exception redirect that waits for an outstanding fetch.
module pipeline_ctrl #(
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       if_busy,
  input  logic       mem_busy,
  input  logic       div_start,
  input  logic       ex_load,
  input  logic       ex_wreg,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       exc_valid,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       flush_w,
  output logic       exc_redirect,
  output logic       div_busy,
  output logic       div_abort
);

  typedef enum logic [1:0] {RUN, DIV, EXC_WAIT} state_e;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic load_use, exc_take;
  logic sf, sd, se, sm, fd, fe, fm, fw, redir, busy, abort;

  assign load_use = ex_load & ex_wreg & (ex_rt != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exc_take = 1'b0;
    busy     = 1'b0;
    abort    = 1'b0;
    redir    = 1'b0;
    sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
    fd = 1'b0; fe = 1'b0; fm = 1'b0; fw = 1'b0;
    case (state_q)
      EXC_WAIT: begin
        // Hold fetch and keep ID empty until the vector fetch can be issued.
        sf = 1'b1;
        fd = 1'b1;
        if (!if_busy) begin
          redir   = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        exc_take = exc_valid & ~mem_busy;
        busy     = (state_q == DIV) | (div_start & ~exc_take);
        sm = mem_busy;
        se = sm | busy;
        sd = se | load_use;
        sf = sd | if_busy;
        fw = sm;
        fm = se & ~sm;
        fe = sd & ~se;
        fd = sf & ~sd;
        if (exc_take) begin
          {fd, fe, fm, fw} = 4'b1111;
          redir   = ~if_busy;
          abort   = (state_q == DIV) | div_start;
          state_d = if_busy ? EXC_WAIT : RUN;
          cnt_d   = 6'd0;
        end else if (state_q == DIV) begin
          // The start cycle was the first busy cycle, so DIV lasts DIV_CYCLES-1.
          if (cnt_q <= 6'd1) begin
            state_d = RUN;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end else if (div_start) begin
          state_d = DIV;
          cnt_d   = DIV_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by reset so they drop the moment resetn falls.
  assign stall_f      = resetn & sf;
  assign stall_d      = resetn & sd;
  assign stall_e      = resetn & se;
  assign stall_m      = resetn & sm;
  assign flush_d      = resetn & fd;
  assign flush_e      = resetn & fe;
  assign flush_m      = resetn & fm;
  assign flush_w      = resetn & fw;
  assign exc_redirect = resetn & redir;
  assign div_busy     = resetn & busy;
  assign div_abort    = resetn & abort;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, corner sequences and
// randomized traffic against an abstract reference model (two DIV_CYCLES values).
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       if_busy, mem_busy, div_start, ex_load, ex_wreg;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       id_use_rs, id_use_rt, exc_valid;
  } in_t;

  typedef struct {
    in_t         i;
    logic [10:0] e;
    string       name;
  } vec_t;

  // Output bit order: sf sd se sm | fd fe fm fw | redirect busy abort
  logic clk = 1'b0, resetn = 1'b0;
  logic if_busy, mem_busy, div_start, ex_load, ex_wreg, id_use_rs, id_use_rt, exc_valid;
  logic [4:0] ex_rt, id_rs, id_rt;
  wire  [10:0] o4, o33;

  int n_vec = 0, n_err = 0;
  int div_left[2];
  bit wait_if[2];
  int dc[2] = '{4, 33};

  always #5 clk = ~clk;

  pipeline_ctrl #(.DIV_CYCLES(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .if_busy(if_busy), .mem_busy(mem_busy),
    .div_start(div_start), .ex_load(ex_load), .ex_wreg(ex_wreg), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exc_valid(exc_valid),
    .stall_f(o4[10]), .stall_d(o4[9]), .stall_e(o4[8]), .stall_m(o4[7]),
    .flush_d(o4[6]), .flush_e(o4[5]), .flush_m(o4[4]), .flush_w(o4[3]),
    .exc_redirect(o4[2]), .div_busy(o4[1]), .div_abort(o4[0]));

  pipeline_ctrl u_dut33 (
    .clk(clk), .resetn(resetn), .if_busy(if_busy), .mem_busy(mem_busy),
    .div_start(div_start), .ex_load(ex_load), .ex_wreg(ex_wreg), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exc_valid(exc_valid),
    .stall_f(o33[10]), .stall_d(o33[9]), .stall_e(o33[8]), .stall_m(o33[7]),
    .flush_d(o33[6]), .flush_e(o33[5]), .flush_m(o33[4]), .flush_w(o33[3]),
    .exc_redirect(o33[2]), .div_busy(o33[1]), .div_abort(o33[0]));

  function automatic in_t mk(bit ifb, bit mb, bit ds, bit ld, bit wr, int ert, int rs,
                             int rt, bit urs, bit urt, bit ev);
    in_t v;
    v.if_busy = ifb; v.mem_busy = mb; v.div_start = ds; v.ex_load = ld; v.ex_wreg = wr;
    v.ex_rt = 5'(ert); v.id_rs = 5'(rs); v.id_rt = 5'(rt);
    v.id_use_rs = urs; v.id_use_rt = urt; v.exc_valid = ev;
    return v;
  endfunction

  task automatic drive(input in_t v);
    @(negedge clk);
    if_busy = v.if_busy; mem_busy = v.mem_busy; div_start = v.div_start;
    ex_load = v.ex_load; ex_wreg = v.ex_wreg; ex_rt = v.ex_rt; id_rs = v.id_rs;
    id_rt = v.id_rt; id_use_rs = v.id_use_rs; id_use_rt = v.id_use_rt;
    exc_valid = v.exc_valid;
    #1;
  endtask

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("reset_out4", o4, 11'b0);
    chk("reset_out33", o33, 11'b0);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin div_left[k] = 0; wait_if[k] = 0; end
  endtask

  // Reference: div_left counts the divide cycles still owed after this one.
  task automatic model(input int k, input in_t v, output logic [10:0] e);
    bit lu, take, in_div, busy, abort, sf, sd, se, sm, fd, fe, fm, fw, red;
    lu = v.ex_load && v.ex_wreg && v.ex_rt != 0 &&
         ((v.id_use_rs && v.id_rs == v.ex_rt) || (v.id_use_rt && v.id_rt == v.ex_rt));
    {sf, sd, se, sm, fd, fe, fm, fw, red, busy, abort} = '0;
    if (wait_if[k]) begin
      sf = 1; fd = 1; red = !v.if_busy;
      if (!v.if_busy) wait_if[k] = 0;
    end else begin
      take   = v.exc_valid && !v.mem_busy;
      in_div = div_left[k] > 0;
      busy   = in_div || (v.div_start && !take);
      abort  = take && (in_div || v.div_start);
      sm = v.mem_busy; se = sm | busy; sd = se | lu; sf = sd | v.if_busy;
      if (take) begin
        {fd, fe, fm, fw} = 4'b1111;
        red = !v.if_busy;
        div_left[k] = 0;
        wait_if[k]  = v.if_busy;
      end else begin
        fw = sm; fm = se & !sm; fe = sd & !se; fd = sf & !sd;
        if (in_div) div_left[k]--;
        else if (v.div_start) div_left[k] = dc[k] - 1;
      end
    end
    e = {sf, sd, se, sm, fd, fe, fm, fw, red, busy, abort};
  endtask

  vec_t tbl[12];
  localparam logic [10:0] LU  = 11'b1100_0100_000;
  localparam logic [10:0] MB  = 11'b1111_0001_000;
  localparam logic [10:0] EW  = 11'b1000_1000_000;

  initial begin
    logic [10:0] e4, e33;
    in_t v;
    {if_busy, mem_busy, div_start, ex_load, ex_wreg, id_use_rs, id_use_rt, exc_valid} = '0;
    {ex_rt, id_rs, id_rt} = '0;
    #2;
    chk("reset_async4", o4, 11'b0);
    chk("reset_async33", o33, 11'b0);
    do_reset();

    tbl[0]  = '{mk(0,0,0,1,1,5,5,0,1,0,0), LU, "lu_rs"};
    tbl[1]  = '{mk(0,0,0,1,1,0,0,0,1,1,0), 11'b0, "lu_rt0"};
    tbl[2]  = '{mk(0,0,0,1,1,7,0,7,0,1,0), LU, "lu_rt"};
    tbl[3]  = '{mk(0,0,0,1,1,7,7,7,0,0,0), 11'b0, "lu_nouse"};
    tbl[4]  = '{mk(0,0,0,1,0,5,5,0,1,0,0), 11'b0, "lu_nowreg"};
    tbl[5]  = '{mk(1,0,0,0,0,0,0,0,0,0,0), EW, "if_busy"};
    tbl[6]  = '{mk(0,1,0,0,0,0,0,0,0,0,0), MB, "mem_busy"};
    tbl[7]  = '{mk(0,1,0,1,1,5,5,0,1,0,0), MB, "mem_lu"};
    tbl[8]  = '{mk(0,0,0,0,0,0,0,0,0,0,1), 11'b0000_1111_100, "exc_take"};
    tbl[9]  = '{mk(0,1,0,0,0,0,0,0,0,0,1), MB, "exc_defer"};
    tbl[10] = '{mk(0,0,0,1,1,5,5,0,1,0,1), 11'b1100_1111_100, "exc_lu"};
    tbl[11] = '{mk(1,0,0,1,1,5,5,0,1,0,0), LU, "lu_ifb"};
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].i);
      chk({tbl[i].name, "_4"}, o4, tbl[i].e);
      chk({tbl[i].name, "_33"}, o33, tbl[i].e);
    end

    // Divide with DIV_CYCLES=4: busy t..t+3, idle at t+4.
    do_reset();
    drive(mk(0,0,1,0,0,0,0,0,0,0,0));
    chk("div_t0", o4, 11'b1110_0010_010);
    for (int c = 1; c < 4; c++) begin
      drive(mk(0,0,c == 2,0,0,0,0,0,0,0,0));
      chk("div_hold", o4, 11'b1110_0010_010);
    end
    drive(mk(0,0,0,0,0,0,0,0,0,0,0));
    chk("div_end", o4, 11'b0);

    // Exception waiting on fetch; other inputs ignored in the wait.
    do_reset();
    drive(mk(1,0,0,0,0,0,0,0,0,0,1));
    chk("exw_c0", o4, 11'b1000_1111_000);
    for (int c = 1; c < 3; c++) begin
      drive(mk(1,1,1,1,1,5,5,0,1,0,1));
      chk("exw_wait", o4, EW);
    end
    drive(mk(0,1,1,0,0,0,0,0,0,0,1));
    chk("exw_redir", o4, 11'b1000_1000_100);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0));
    chk("exw_run", o4, 11'b0);

    // Exception deferred by mem_busy.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(mk(0,1,0,0,0,0,0,0,0,0,1));
      chk("exd_hold", o33, MB);
    end
    drive(mk(0,0,0,0,0,0,0,0,0,0,1));
    chk("exd_take", o33, 11'b0000_1111_100);

    // Abort a long divide in its third cycle.
    do_reset();
    drive(mk(0,0,1,0,0,0,0,0,0,0,0));
    drive(mk(0,0,0,0,0,0,0,0,0,0,0));
    chk("abt_run", o33, 11'b1110_0010_010);
    drive(mk(0,0,0,0,0,0,0,0,0,0,1));
    chk("abt_pulse", o33, 11'b1110_1111_111);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0));
    chk("abt_after", o33, 11'b0);

    // Reset in EXC_WAIT.
    do_reset();
    drive(mk(1,0,0,0,0,0,0,0,0,0,1));
    drive(mk(1,0,0,0,0,0,0,0,0,0,0));
    chk("rw_wait", o4, EW);
    #2 resetn = 1'b0;
    #1 chk("rw_async", o4, 11'b0);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0));
    resetn = 1'b1;
    #1 chk("rw_noredir", o4, 11'b0);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0));
    chk("rw_run", o4, 11'b0);

    // Randomized traffic vs reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        v = mk($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
               $urandom_range(1), $urandom_range(3) != 0, $urandom_range(3),
               $urandom_range(3), $urandom_range(3), $urandom_range(1),
               $urandom_range(1), $urandom_range(9) == 0);
        drive(v);
        model(0, v, e4);
        model(1, v, e33);
        chk("rand4", o4, e4);
        chk("rand33", o33, e33);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
